// File: rtl/mpu_bus_bridge_pkg.sv
// Shared definitions for the MPU read-bus bridge: register map, STATUS bit
// positions, default ID and prefetch FSM states.
package mpu_bus_bridge_pkg;

    localparam int REG_STATUS = 0;
    localparam int REG_DATA   = 1;
    localparam int REG_COUNT  = 2;
    localparam int REG_ID     = 3;

    localparam int STAT_VALID    = 0;
    localparam int STAT_READY    = 1;
    localparam int STAT_UNDERRUN = 2;

    localparam int          COUNT_WIDTH       = 16;
    localparam logic [15:0] DEFAULT_BRIDGE_ID = 16'h0A51;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_HOLD  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/mpu_bus_bridge_sync_ff.sv
// Multi-flop synchronizer for one asynchronous strobe; resets to the
// strobe's idle (high) level so no false edge appears after reset.
module mpu_bus_bridge_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe_q;
    logic [STAGES-1:0] pipe_d;

    always_comb begin
        pipe_d = {pipe_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '1;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign q = pipe_q[STAGES-1];

endmodule

// File: rtl/mpu_bus_bridge.sv
// Slave bridge from the asynchronous MPU read bus to tag_data_buff: strobe
// synchronization, 4-register read map and a one-word prefetch buffer.
module mpu_bus_bridge
    import mpu_bus_bridge_pkg::*;
#(
    parameter int                    READ_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [READ_WIDTH-1:0] BRIDGE_ID   = READ_WIDTH'(DEFAULT_BRIDGE_ID)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mpu_cs_n,
    input  logic                  mpu_oe_n,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    output logic [READ_WIDTH-1:0] mpu_data,
    output logic                  mpu_data_oe,
    output logic                  mpu_irq,
    input  logic                  buff_ready,
    input  logic [READ_WIDTH-1:0] buff_data,
    output logic                  buff_rd_ena
);

    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(REG_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(REG_DATA);
    localparam logic [ADDR_WIDTH-1:0] A_COUNT  = ADDR_WIDTH'(REG_COUNT);
    localparam logic [ADDR_WIDTH-1:0] A_ID     = ADDR_WIDTH'(REG_ID);

    logic [1:0]             rst_pipe_q, rst_pipe_d;
    logic                   rst_int;
    logic                   cs_s, oe_s;
    logic                   oe_prev_q, oe_prev_d;
    logic                   rd_start, rd_done, pop_req;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   data_hit_q, data_hit_d;
    logic                   underrun_q, underrun_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [READ_WIDTH-1:0]  hold_q, hold_d;
    logic [READ_WIDTH-1:0]  mpu_data_q, mpu_data_d;
    logic                   mpu_data_oe_q, mpu_data_oe_d;
    logic [READ_WIDTH-1:0]  status, rd_mux;
    fetch_state_e           state_q, state_d;

    // Asserts with rst immediately, releases two clk edges after rst drops.
    always_comb begin
        rst_pipe_d = {rst_pipe_q[0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe_q <= 2'b11;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_int = rst_pipe_q[1];

    mpu_bus_bridge_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk (clk),
        .rst (rst_int),
        .d   (mpu_cs_n),
        .q   (cs_s)
    );

    mpu_bus_bridge_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk (clk),
        .rst (rst_int),
        .d   (mpu_oe_n),
        .q   (oe_s)
    );

    assign rd_start = ~cs_s &  oe_prev_q & ~oe_s;
    assign rd_done  = ~cs_s & ~oe_prev_q &  oe_s;
    // Only a DATA access that actually returned the held word may pop it.
    assign pop_req  = rd_done & (addr_q == A_DATA) & data_hit_q;

    always_comb begin
        status                = '0;
        status[STAT_VALID]    = valid_q;
        status[STAT_READY]    = buff_ready;
        status[STAT_UNDERRUN] = underrun_q;
        rd_mux                = '0;
        case (mpu_addr)
            A_STATUS: rd_mux = status;
            A_DATA:   rd_mux = valid_q ? hold_q : '0;
            A_COUNT:  rd_mux = READ_WIDTH'(count_q);
            A_ID:     rd_mux = BRIDGE_ID;
            default:  rd_mux = '0;
        endcase
    end

    // NOTE: every signal this block writes gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        oe_prev_d     = oe_s;
        mpu_data_oe_d = ~cs_s & ~oe_s;
        addr_d        = addr_q;
        data_hit_d    = data_hit_q;
        mpu_data_d    = mpu_data_q;
        underrun_d    = underrun_q;
        if (rd_done && addr_q == A_STATUS) begin
            underrun_d = 1'b0;
        end
        if (rd_start) begin
            addr_d     = mpu_addr;
            mpu_data_d = rd_mux;
            data_hit_d = (mpu_addr == A_DATA) && valid_q;
            if (mpu_addr == A_DATA && !valid_q) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        valid_d     = valid_q;
        count_d     = count_q;
        buff_rd_ena = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (buff_ready) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                buff_rd_ena = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: state_d = ST_LATCH;
            ST_LATCH: begin
                hold_d  = buff_data;
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (pop_req) begin
                    count_d = count_q + 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            oe_prev_q     <= 1'b1;
            mpu_data_oe_q <= 1'b0;
            addr_q        <= '0;
            data_hit_q    <= 1'b0;
            mpu_data_q    <= '0;
            underrun_q    <= 1'b0;
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            valid_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            oe_prev_q     <= oe_prev_d;
            mpu_data_oe_q <= mpu_data_oe_d;
            addr_q        <= addr_d;
            data_hit_q    <= data_hit_d;
            mpu_data_q    <= mpu_data_d;
            underrun_q    <= underrun_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
        end
    end

    assign mpu_data    = mpu_data_q;
    assign mpu_data_oe = mpu_data_oe_q;
    assign mpu_irq     = valid_q;

endmodule

// File: tb/tb_mpu_bus_bridge.sv
// Self-checking bench for mpu_bus_bridge: register table, prefetch, underrun,
// pulse spacing, abort, COUNT wrap and a randomized scoreboard run.
module tb_mpu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mpu_cs_n, mpu_oe_n;
    logic [1:0]  mpu_addr;
    logic [15:0] mpu_data;
    logic        mpu_data_oe, mpu_irq;
    logic        buff_ready = 1'b0;
    logic [15:0] buff_data = 16'h0000;
    logic        buff_rd_ena;

    int n_checks = 0;
    int n_fail   = 0;

    mpu_bus_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .mpu_cs_n    (mpu_cs_n),
        .mpu_oe_n    (mpu_oe_n),
        .mpu_addr    (mpu_addr),
        .mpu_data    (mpu_data),
        .mpu_data_oe (mpu_data_oe),
        .mpu_irq     (mpu_irq),
        .buff_ready  (buff_ready),
        .buff_data   (buff_data),
        .buff_rd_ena (buff_rd_ena)
    );

    always #5 clk = ~clk;

    // FIFO model: pushed words become visible at the next edge; one pop per
    // rd_ena-high edge, data available on the edge of the pop.
    logic [15:0] words[$];
    int          rd_idx    = 0;
    int          pop_empty = 0;

    always @(posedge clk) begin : fifo_model
        int nxt;
        nxt = rd_idx;
        if (buff_rd_ena) begin
            if (rd_idx < words.size()) begin
                buff_data <= words[rd_idx];
                nxt = rd_idx + 1;
            end else begin
                pop_empty++;
            end
        end
        rd_idx     <= nxt;
        buff_ready <= (nxt < words.size());
    end

    // rd_ena pulse shape observer.
    int pulse_cnt = 0;
    int hi_run    = 0;
    int lo_run    = 0;
    int max_width = 0;
    int min_gap   = 1000;

    always @(negedge clk) begin
        if (buff_rd_ena) begin
            if (hi_run == 0) begin
                if (pulse_cnt > 0 && lo_run < min_gap) min_gap = lo_run;
                pulse_cnt++;
            end
            hi_run++;
            if (hi_run > max_width) max_width = hi_run;
            lo_run = 0;
        end else begin
            hi_run = 0;
            lo_run++;
        end
    end

    // Reference model state.
    logic [15:0] exp_q[$];
    logic [15:0] count_model = 16'h0000;

    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        words.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!mpu_irq && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("irq_wait", {31'b0, mpu_irq}, 32'd1);
    endtask

    task automatic mpu_read(input logic [1:0] a, input int skew, input int extra,
                            input int gap, output logic [15:0] d);
        @(posedge clk);
        #($urandom_range(2, 7));
        mpu_addr = a;
        mpu_cs_n = 1'b0;
        if (skew > 0) begin
            repeat (skew) @(posedge clk);
            #($urandom_range(2, 7));
        end
        mpu_oe_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d = mpu_data;
        check("data_oe_during_read", {31'b0, mpu_data_oe}, 32'd1);
        repeat (extra) @(posedge clk);
        #($urandom_range(1, 6));
        mpu_oe_n = 1'b1;
        repeat (2) @(posedge clk);
        #($urandom_range(2, 7));
        mpu_cs_n = 1'b1;
        repeat (1 + gap) @(posedge clk);
        #1;
    endtask

    task automatic data_read(input bit min_timing);
        logic [15:0] d, e;
        if (exp_q.size() == 0) push_word(16'($urandom_range(0, 16'hFFFF)));
        wait_irq();
        if (min_timing) mpu_read(2'd1, 0, 0, 0, d);
        else mpu_read(2'd1, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), d);
        e = exp_q.pop_front();
        check("data_word", {16'b0, d}, {16'b0, e});
        count_model++;
    endtask

    task automatic reg_check(input string name, input logic [1:0] a, input logic [15:0] e);
        logic [15:0] d;
        mpu_read(a, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), d);
        check(name, {16'b0, d}, {16'b0, e});
    endtask

    task automatic abort_read();
        if (exp_q.size() == 0) push_word(16'($urandom_range(0, 16'hFFFF)));
        wait_irq();
        @(posedge clk);
        #($urandom_range(2, 7));
        mpu_addr = 2'd1;
        mpu_cs_n = 1'b0;
        mpu_oe_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_data", {16'b0, mpu_data}, {16'b0, exp_q[0]});
        #($urandom_range(1, 6));
        mpu_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe_drop", {31'b0, mpu_data_oe}, 32'd0);
        #($urandom_range(1, 6));
        mpu_oe_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_word_kept", {31'b0, mpu_irq}, 32'd1);
    endtask

    initial begin
        int p0;
        logic [15:0] d;

        rst      = 1'b1;
        mpu_cs_n = 1'b1;
        mpu_oe_n = 1'b1;
        mpu_addr = 2'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset asserted while a word is held.
        reg_check("id_first", 2'd3, 16'h0A51);
        push_word(16'hCAFE);
        wait_irq();
        reg_check("status_holding", 2'd0, 16'h0001);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_mpu_data", {16'b0, mpu_data}, 32'd0);
        check("rst_irq", {31'b0, mpu_irq}, 32'd0);
        check("rst_data_oe", {31'b0, mpu_data_oe}, 32'd0);
        check("rst_rd_ena", {31'b0, buff_rd_ena}, 32'd0);
        void'(exp_q.pop_front());
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Register table from a quiet state, including the underrun sequence.
        tbl[0] = '{addr: 2'd0, exp: 16'h0000};
        tbl[1] = '{addr: 2'd3, exp: 16'h0A51};
        tbl[2] = '{addr: 2'd2, exp: 16'h0000};
        tbl[3] = '{addr: 2'd1, exp: 16'h0000};
        tbl[4] = '{addr: 2'd0, exp: 16'h0004};
        tbl[5] = '{addr: 2'd0, exp: 16'h0000};
        tbl[6] = '{addr: 2'd2, exp: 16'h0000};
        for (int i = 0; i < 7; i++) begin
            reg_check($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
        end

        // Prefetch latency and ordering.
        push_word(16'h1234);
        push_word(16'h5678);
        @(posedge clk);
        #1;
        p0 = pulse_cnt;
        check("irq_before_fetch", {31'b0, mpu_irq}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("irq_by_cycle4", {31'b0, mpu_irq}, 32'd1);
        check("one_pulse", pulse_cnt - p0, 32'd1);
        data_read(1'b0);
        data_read(1'b0);
        reg_check("count_after_two", 2'd2, count_model);

        // Back-to-back reads at minimum timing.
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) push_word(16'h0A00 + 16'(i * 17));
        for (int i = 0; i < 8; i++) data_read(1'b1);
        check("eight_pulses", pulse_cnt - p0, 32'd8);
        reg_check("count_after_burst", 2'd2, count_model);

        // Abort keeps the word and the count.
        abort_read();
        reg_check("count_after_abort", 2'd2, count_model);
        data_read(1'b0);

        // COUNT wrap.
        repeat (6) @(posedge clk);
        force dut.count_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        release dut.count_q;
        #1;
        count_model = 16'hFFFF;
        reg_check("count_preload", 2'd2, count_model);
        data_read(1'b0);
        reg_check("count_wrapped", 2'd2, 16'h0000);

        // Randomized traffic against the scoreboard.
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (exp_q.size() < 3 && $urandom_range(0, 1) == 1)
                push_word(16'($urandom_range(0, 16'hFFFF)));
            if (op <= 5) data_read(1'b0);
            else if (op == 6) abort_read();
            else if (op <= 8) reg_check("rand_count", 2'd2, count_model);
            else reg_check("rand_id", 2'd3, 16'h0A51);
        end
        while (exp_q.size() > 0) data_read(1'b0);
        reg_check("count_final", 2'd2, count_model);

        check("pulse_width_1", max_width, 32'd1);
        check("pulse_gap_ge3", {31'b0, (min_gap >= 3)}, 32'd1);
        check("no_pop_on_empty", pop_empty, 32'd0);
        check("pulses_eq_words", pulse_cnt, words.size());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
